router_out_fifo: RTL and testbench

- Per-destination output buffer of the 1x3 router, i.e. the source side of the destination interface.
- Accepts bytes from the router write path, presents them as data_out/valid_out, and pops on the destination's read_enb.
- Tracks packet boundaries: header byte -> payload length -> parity.
- Self-flushes with a soft_reset pulse when the destination leaves valid data unread for TIMEOUT cycles.

---
 rtl/router_out_fifo_pkg.sv | 20 ++
 rtl/router_out_fifo_if.sv | 24 ++
 rtl/router_out_fifo_timer.sv | 32 +++
 rtl/router_out_fifo.sv | 76 +++++++
 tb/tb_router_out_fifo.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/router_out_fifo_pkg.sv
// Shared types and defaults for the router output buffer slice.
// Entries carry the header flag alongside the byte so packet boundaries survive the FIFO.
package router_pkg;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 16;
    localparam int TIMEOUT   = 30;
    localparam int PKT_CNT_W = 7;

    typedef struct packed {
        logic             hdr;
        logic [WIDTH-1:0] data;
    } fifo_entry_t;

    // Header byte carries the payload length in its upper six bits
    function automatic logic [5:0] hdr_len(input logic [WIDTH-1:0] b);
        return b[7:2];
    endfunction

endpackage

// File: rtl/router_out_fifo_if.sv
// Handshake bundle between the router write path / destination and one output buffer.
interface router_out_fifo_if #(
    parameter int WIDTH = router_pkg::WIDTH
);
    logic             write_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic             read_enb;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             full;
    logic             empty;
    logic             soft_reset;

    modport master (
        output write_enb, lfd_state, data_in, read_enb,
        input  data_out, valid_out, full, empty, soft_reset
    );

    modport slave (
        input  write_enb, lfd_state, data_in, read_enb,
        output data_out, valid_out, full, empty, soft_reset
    );
endinterface

// File: rtl/router_out_fifo_timer.sv
// Counts consecutive unread cycles; expire flags the flush edge, soft_reset echoes it one cycle later.
module router_out_timer #(
    parameter int TIMEOUT = router_pkg::TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    input  logic valid_out,
    input  logic read_enb,
    output logic expire,
    output logic soft_reset
);
    localparam int TW = $clog2(TIMEOUT) + 1;

    logic [TW-1:0] timer;
    logic          waiting;

    assign waiting = valid_out && !read_enb;
    assign expire  = waiting && (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            timer      <= '0;
            soft_reset <= 1'b0;
        end else begin
            soft_reset <= expire;
            if (!waiting || expire)
                timer <= '0;
            else
                timer <= timer + 1'b1;
        end
    end
endmodule

// File: rtl/router_out_fifo.sv
// Per-destination output FIFO of the 1x3 router with packet-length tracking and
// a self-flush when the destination stops reading.
module router_out_fifo
    import router_pkg::*;
#(
    parameter int WIDTH   = router_pkg::WIDTH,
    parameter int DEPTH   = router_pkg::DEPTH,
    parameter int TIMEOUT = router_pkg::TIMEOUT
) (
    input logic              clock,
    input logic              reset,
    router_out_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    fifo_entry_t          mem [DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [PKT_CNT_W-1:0] pkt_count;
    logic [WIDTH-1:0]     data_out_q;
    fifo_entry_t          rd_entry;
    logic                 empty;
    logic                 full;
    logic                 do_push;
    logic                 do_pop;
    logic                 expire;
    logic                 soft_reset;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_entry = mem[rd_ptr[AW-1:0]];
    // A push landing on the flush edge is discarded with the rest of the contents
    assign do_push  = bus.write_enb && !full && !expire;
    assign do_pop   = bus.read_enb && !empty;

    router_out_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock      (clock),
        .reset      (reset),
        .valid_out  (!empty),
        .read_enb   (bus.read_enb),
        .expire     (expire),
        .soft_reset (soft_reset)
    );

    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= '{hdr: bus.lfd_state, data: bus.data_in};
    end

    always_ff @(posedge clock) begin
        if (reset || expire) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pkt_count  <= '0;
            data_out_q <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                data_out_q <= rd_entry.data;
                // Header reload counts payload bytes plus the trailing parity byte
                if (rd_entry.hdr)
                    pkt_count <= PKT_CNT_W'(hdr_len(rd_entry.data)) + 1'b1;
                else if (pkt_count != '0)
                    pkt_count <= pkt_count - 1'b1;
            end
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.valid_out  = !empty;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.soft_reset = soft_reset;
endmodule

// File: tb/tb_router_out_fifo.sv
// Directed bench for router_out_fifo: ordering, full/empty corners, timeout flush,
// mid-stream reset and packet-length counting across pointer wrap.
module tb_router_out_fifo;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    router_out_fifo_if bus_if ();

    router_out_fifo dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, input logic lfd);
        bus_if.write_enb = 1'b1;
        bus_if.lfd_state = lfd;
        bus_if.data_in   = b;
        step();
        bus_if.write_enb = 1'b0;
        bus_if.lfd_state = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp_data, input int exp_pkt);
        bus_if.read_enb = 1'b1;
        step();
        bus_if.read_enb = 1'b0;
        chk({tag, "_data"}, 32'(bus_if.data_out), 32'(exp_data));
        chk({tag, "_pkt"}, 32'(dut.pkt_count), 32'(exp_pkt));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_empty"}, 32'(bus_if.empty), 32'd1);
        chk({tag, "_full"}, 32'(bus_if.full), 32'd0);
        chk({tag, "_valid"}, 32'(bus_if.valid_out), 32'd0);
        chk({tag, "_dout"}, 32'(bus_if.data_out), 32'd0);
        chk({tag, "_soft"}, 32'(bus_if.soft_reset), 32'd0);
        chk({tag, "_pkt"}, 32'(dut.pkt_count), 32'd0);
    endtask

    initial begin
        bus_if.write_enb = 1'b0;
        bus_if.lfd_state = 1'b0;
        bus_if.data_in   = '0;
        bus_if.read_enb  = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk_idle("rst");

        // 1: one short packet
        push(8'h0C, 1'b1);
        push(8'hA1, 1'b0);
        push(8'hA2, 1'b0);
        push(8'hA3, 1'b0);
        push(8'h5E, 1'b0);
        chk("t1_valid", 32'(bus_if.valid_out), 32'd1);
        pop_chk("t1_p0", 8'h0C, 4);
        pop_chk("t1_p1", 8'hA1, 3);
        pop_chk("t1_p2", 8'hA2, 2);
        pop_chk("t1_p3", 8'hA3, 1);
        pop_chk("t1_p4", 8'h5E, 0);
        chk("t1_empty", 32'(bus_if.empty), 32'd1);

        // 2: fill to full, overflow dropped
        for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
        chk("t2_full", 32'(bus_if.full), 32'd1);
        push(8'hFF, 1'b0);
        chk("t2_full_ovf", 32'(bus_if.full), 32'd1);
        for (int i = 0; i < 16; i++) pop_chk("t2_pop", 8'(i), 0);
        chk("t2_empty", 32'(bus_if.empty), 32'd1);

        // 3: simultaneous push/pop at full and at empty
        for (int i = 0; i < 16; i++) push(8'h40 + 8'(i), 1'b0);
        chk("t3_full", 32'(bus_if.full), 32'd1);
        bus_if.write_enb = 1'b1;
        bus_if.data_in   = 8'h77;
        pop_chk("t3_fullpp", 8'h40, 0);
        bus_if.write_enb = 1'b0;
        chk("t3_notfull", 32'(bus_if.full), 32'd0);
        for (int i = 1; i < 16; i++) pop_chk("t3_drain", 8'h40 + 8'(i), 0);
        chk("t3_empty", 32'(bus_if.empty), 32'd1);
        bus_if.write_enb = 1'b1;
        bus_if.data_in   = 8'h33;
        pop_chk("t3_emptypp", 8'h4F, 0);
        bus_if.write_enb = 1'b0;
        chk("t3_nonempty", 32'(bus_if.empty), 32'd0);
        pop_chk("t3_p33", 8'h33, 0);

        // 4a: 30 unread cycles flush the FIFO
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        for (int i = 0; i < 27; i++) step();
        chk("t4_pre_soft", 32'(bus_if.soft_reset), 32'd0);
        chk("t4_pre_empty", 32'(bus_if.empty), 32'd0);
        chk("t4_pre_dout", 32'(bus_if.data_out), 32'h33);
        step();
        chk("t4_soft", 32'(bus_if.soft_reset), 32'd1);
        chk("t4_empty", 32'(bus_if.empty), 32'd1);
        chk("t4_dout", 32'(bus_if.data_out), 32'd0);
        step();
        chk("t4_soft_once", 32'(bus_if.soft_reset), 32'd0);

        // 4b: a read in cycle 29 restarts the count
        push(8'h55, 1'b0);
        push(8'h66, 1'b0);
        push(8'h77, 1'b0);
        for (int i = 0; i < 26; i++) step();
        pop_chk("t4b_pop", 8'h55, 0);
        chk("t4b_nosoft", 32'(bus_if.soft_reset), 32'd0);
        step();
        chk("t4b_nosoft2", 32'(bus_if.soft_reset), 32'd0);
        for (int i = 0; i < 28; i++) step();
        chk("t4b_pre_soft", 32'(bus_if.soft_reset), 32'd0);
        chk("t4b_pre_empty", 32'(bus_if.empty), 32'd0);
        step();
        chk("t4b_soft", 32'(bus_if.soft_reset), 32'd1);
        chk("t4b_empty", 32'(bus_if.empty), 32'd1);
        step();

        // 5: reset mid-stream
        push(8'h08, 1'b1);
        push(8'h91, 1'b0);
        push(8'h92, 1'b0);
        push(8'h93, 1'b0);
        pop_chk("t5_hdr", 8'h08, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_idle("t5_rst");
        push(8'h9C, 1'b0);
        pop_chk("t5_9c", 8'h9C, 0);
        chk("t5_empty", 32'(bus_if.empty), 32'd1);

        // 6: max-length packet drained while refilling
        push(8'hFC, 1'b1);
        for (int i = 1; i < 16; i++) push(8'(i), 1'b0);
        chk("t6_full", 32'(bus_if.full), 32'd1);
        pop_chk("t6_hdr", 8'hFC, 64);
        for (int j = 1; j <= 49; j++) begin
            bus_if.write_enb = 1'b1;
            bus_if.data_in   = 8'(15 + j);
            pop_chk("t6_pp", 8'(j), 64 - j);
            bus_if.write_enb = 1'b0;
        end
        for (int k = 50; k <= 64; k++) pop_chk("t6_drain", 8'(k), 64 - k);
        chk("t6_empty", 32'(bus_if.empty), 32'd1);
        pop_chk("t6_idle_pop", 8'd64, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
